// File: rtl/timer_peripheral.sv
// Memory-mapped reload/count timer with interrupt, answering CPU loads/stores in its address window.
// Optional free-running SYSTICK register at offset 0x0C is enabled by defining TIMER_SYSTICK_EN.
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter int unsigned PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        hit,
    output logic        irqout
);
    // Bus protocol: MemRead/MemWrite are single-cycle valids qualified by hit; the
    // responder is always ready, loads answer combinationally, stores commit at posedge.

    localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        status_q, status_d;
    logic [15:0] prescale_q, prescale_d;

    logic        in_window;
    logic [1:0]  offset;
    logic        sel_th, sel_tl, sel_tcon, sel_sys;
    logic        tick, overflow;
    logic [31:0] tcon_val;

`ifdef TIMER_SYSTICK_EN
    logic [31:0] systick_q, systick_d;
`endif

    assign in_window = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
    assign offset    = Address[3:2];
    assign sel_th    = in_window && (offset == 2'd0);
    assign sel_tl    = in_window && (offset == 2'd1);
    assign sel_tcon  = in_window && (offset == 2'd2);
`ifdef TIMER_SYSTICK_EN
    assign sel_sys   = in_window && (offset == 2'd3);
`else
    assign sel_sys   = 1'b0;
`endif
    assign hit       = sel_th || sel_tl || sel_tcon || sel_sys;

    assign tcon_val  = {29'd0, status_q, ie_q, en_q};
    assign tick      = en_q && (prescale_q == PRESCALE_MAX);
    assign overflow  = tick && (tl_q == 32'hFFFF_FFFF);
    assign irqout    = ie_q && status_q;

    always_comb begin
        ReadData = '0;
        if (MemRead && hit) begin
            case (offset)
                2'd0:    ReadData = th_q;
                2'd1:    ReadData = tl_q;
                2'd2:    ReadData = tcon_val;
`ifdef TIMER_SYSTICK_EN
                2'd3:    ReadData = systick_q;
`endif
                default: ReadData = '0;
            endcase
        end
    end

    always_comb begin
        th_d       = th_q;
        tl_d       = tl_q;
        en_d       = en_q;
        ie_d       = ie_q;
        status_d   = status_q;
        prescale_d = prescale_q;

        if (MemWrite && sel_th) th_d = WriteData;

        // A CPU store to TL beats both the increment and the reload.
        if (MemWrite && sel_tl)  tl_d = WriteData;
        else if (overflow)       tl_d = th_q;
        else if (tick)           tl_d = tl_q + 32'd1;

        if (MemWrite && sel_tcon) begin
            en_d = WriteData[0];
            ie_d = WriteData[1];
            if (WriteData[2]) status_d = 1'b0;
        end
        if (overflow && ie_q) status_d = 1'b1;

        // Prescaler stays at zero while disabled and is cleared on the disabling edge.
        if (!en_q || !en_d)                prescale_d = '0;
        else if (prescale_q == PRESCALE_MAX) prescale_d = '0;
        else                               prescale_d = prescale_q + 16'd1;
    end

`ifdef TIMER_SYSTICK_EN
    assign systick_d = systick_q + 32'd1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            th_q       <= '0;
            tl_q       <= '0;
            en_q       <= 1'b0;
            ie_q       <= 1'b0;
            status_q   <= 1'b0;
            prescale_q <= '0;
`ifdef TIMER_SYSTICK_EN
            systick_q  <= '0;
`endif
        end else begin
            th_q       <= th_d;
            tl_q       <= tl_d;
            en_q       <= en_d;
            ie_q       <= ie_d;
            status_q   <= status_d;
            prescale_q <= prescale_d;
`ifdef TIMER_SYSTICK_EN
            systick_q  <= systick_d;
`endif
        end
    end
endmodule

// File: tb/tb_timer_peripheral.sv
// Scoreboard bench for timer_peripheral: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_timer_peripheral;
    logic        clk;
    logic        reset;
    logic        rd1, wr1, rd4, wr4;
    logic [31:0] addr1, wd1, addr4, wd4;
    logic [31:0] rdata1, rdata4;
    logic        hit1, hit4, irq1, irq4;
    logic [31:0] cyc;

    logic [33:0] exp_q[$];
    string       name_q[$];
    int          checks;
    int          failures;

    localparam logic [31:0] TH   = 32'h4000_0000;
    localparam logic [31:0] TL   = 32'h4000_0004;
    localparam logic [31:0] TCON = 32'h4000_0008;
    localparam logic [31:0] SYS  = 32'h4000_000C;

    timer_peripheral #(.BASE_ADDR(32'h4000_0000), .PRESCALE(1)) u_dut1 (
        .clk(clk), .reset(reset), .MemRead(rd1), .MemWrite(wr1), .Address(addr1),
        .WriteData(wd1), .ReadData(rdata1), .hit(hit1), .irqout(irq1)
    );

    timer_peripheral #(.BASE_ADDR(32'h4000_0000), .PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(reset), .MemRead(rd4), .MemWrite(wr4), .Address(addr4),
        .WriteData(wd4), .ReadData(rdata4), .hit(hit4), .irqout(irq4)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // cycles since reset release, i.e. the value a free-running tick counter must show
    always @(posedge clk) cyc <= reset ? 32'd0 : cyc + 32'd1;

    // driver tasks
    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int d, input logic [31:0] addr, input logic [31:0] data);
        if (d == 1) begin addr1 = addr; wd1 = data; wr1 = 1'b1; end
        else        begin addr4 = addr; wd4 = data; wr4 = 1'b1; end
        @(posedge clk);
        #1;
        wr1 = 1'b0;
        wr4 = 1'b0;
    endtask

    task automatic bus_access(input int d, input logic [31:0] addr, input logic do_wr,
                              input logic [31:0] data, input logic exp_hit,
                              input logic [31:0] exp_data, input logic exp_irq, input string name);
        exp_q.push_back({exp_irq, exp_hit, exp_data});
        name_q.push_back(name);
        if (d == 1) begin addr1 = addr; wd1 = data; rd1 = 1'b1; wr1 = do_wr; end
        else        begin addr4 = addr; wd4 = data; rd4 = 1'b1; wr4 = do_wr; end
        @(posedge clk);
        #1;
        rd1 = 1'b0; wr1 = 1'b0;
        rd4 = 1'b0; wr4 = 1'b0;
    endtask

    task automatic bus_read(input int d, input logic [31:0] addr, input logic exp_hit,
                            input logic [31:0] exp_data, input logic exp_irq, input string name);
        bus_access(d, addr, 1'b0, 32'd0, exp_hit, exp_data, exp_irq, name);
    endtask

    // monitor / scoreboard: every load presented to a DUT is checked against the queue
    always @(negedge clk) begin
        logic [33:0] act;
        logic [33:0] e;
        string       n;
        if (!reset && (rd1 || rd4)) begin
            act = rd1 ? {irq1, hit1, rdata1} : {irq4, hit4, rdata4};
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_read actual irq/hit/data=%h required=none", act);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL %s actual irq=%b hit=%b data=%h required irq=%b hit=%b data=%h",
                             n, act[33], act[32], act[31:0], e[33], e[32], e[31:0]);
                end
            end
        end
    end

    initial begin
        checks = 0;
        failures = 0;
        rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
        rd4 = 0; wr4 = 0; addr4 = 0; wd4 = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        bus_read(1, TH,   1, 32'h0, 0, "reset_th");
        bus_read(1, TL,   1, 32'h0, 0, "reset_tl");
        bus_read(1, TCON, 1, 32'h0, 0, "reset_tcon");

        // reload and interrupt at PRESCALE=1
        bus_write(1, TH,   32'hFFFF_FFFC);
        bus_write(1, TL,   32'hFFFF_FFFE);
        bus_write(1, TCON, 32'h3);
        bus_read(1, TL,   1, 32'hFFFF_FFFE, 0, "count_start");
        bus_read(1, TL,   1, 32'hFFFF_FFFF, 0, "count_max");
        bus_read(1, TL,   1, 32'hFFFF_FFFC, 1, "reload_irq");
        bus_read(1, TCON, 1, 32'h7,         1, "tcon_status");

        // status clear, then clear colliding with an overflow
        bus_write(1, TCON, 32'h2);
        bus_write(1, TL,   32'hFFFF_FFFF);
        bus_read(1, TCON, 1, 32'h6,         1, "disabled_status");
        bus_write(1, TCON, 32'h7);
        bus_read(1, TCON, 1, 32'h3,         0, "status_cleared");
        bus_read(1, TL,   1, 32'hFFFF_FFFC, 1, "reload_again");
        idle();
        idle();
        bus_write(1, TCON, 32'h7);
        bus_read(1, TCON, 1, 32'h7,         1, "set_beats_clear");
        bus_read(1, TL,   1, 32'hFFFF_FFFD, 1, "count_after_clear");

        // IE masks irqout without losing status
        bus_write(1, TCON, 32'h1);
        bus_read(1, TCON, 1, 32'h5,         0, "ie_mask");
        bus_write(1, TCON, 32'h3);
        bus_read(1, TCON, 1, 32'h7,         1, "ie_reassert");

        // write to TL wins over a tick
        bus_write(1, TL, 32'h10);
        bus_write(1, TL, 32'h100);
        bus_read(1, TL, 1, 32'h100, 1, "write_priority");
        bus_read(1, TL, 1, 32'h101, 1, "count_after_write");
        bus_write(1, TCON, 32'h2);

        // misaligned / unmapped accesses
        bus_write(1, 32'h4000_0006, 32'h0000_DEAD);
        bus_write(1, 32'h4000_0010, 32'h0000_BEEF);
        bus_read(1, 32'h4000_0006, 0, 32'h0, 1, "misaligned_read");
        bus_read(1, 32'h4000_0010, 0, 32'h0, 1, "unmapped_read");
        bus_read(1, TL,   1, 32'h103,       1, "tl_frozen_untouched");
        bus_read(1, TH,   1, 32'hFFFF_FFFC, 1, "th_untouched");
        bus_read(1, TCON, 1, 32'h6,         1, "tcon_disabled");

        // simultaneous load and store returns the pre-write value
        bus_access(1, TL, 1'b1, 32'h55, 1, 32'h103, 1, "read_during_write");
        bus_read(1, TL, 1, 32'h55, 1, "write_committed");

`ifdef TIMER_SYSTICK_EN
        bus_read(1, SYS, 1, cyc, 1, "systick_first");
        repeat (9) idle();
        bus_read(1, SYS, 1, cyc, 1, "systick_plus10");
        bus_write(1, SYS, 32'h0);
        bus_read(1, SYS, 1, cyc, 1, "systick_store_ignored");
`else
        bus_write(1, SYS, 32'h5);
        bus_read(1, SYS, 0, 32'h0, 1, "systick_unmapped");
        bus_read(1, TL,  1, 32'h55, 1, "systick_store_ignored");
`endif

        bus_write(1, TCON, 32'h4);
        bus_read(1, TCON, 1, 32'h0, 0, "final_clear");

        // PRESCALE=4: one increment per four cycles, freeze and resume
        bus_write(4, TCON, 32'h1);
        for (int k = 0; k < 9; k++)
            bus_read(4, TL, 1, 32'(k / 4), 0, $sformatf("prescale_k%0d", k));
        bus_write(4, TCON, 32'h0);
        repeat (6) idle();
        bus_read(4, TL, 1, 32'h2, 0, "prescale_frozen");
        bus_write(4, TCON, 32'h1);
        for (int k = 0; k < 5; k++)
            bus_read(4, TL, 1, 32'h2 + 32'(k / 4), 0, $sformatf("resume_k%0d", k));

        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
